uart_tx_arbiter: RTL and testbench

- Shares one 8N1 UART byte transmitter among N_REQ requesters, e.g. keypad scan reporter, debug console and status beacon.
- Round-robin arbitration; a requester may lock the transmitter for a multi-byte message using req_last.
- Holds tx_data stable for the whole frame and issues a single-cycle tx_trigger per byte.
- A watchdog releases the grant if the transmitter or the lock owner stalls.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and frame/timeout defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 20000;
  localparam int FRAME_BITS             = 10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    logic [W-1:0] cand;
    cand  = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 byte transmitter among N_REQ requesters with round-robin, message lock and watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int GW             = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_trigger,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               err_timeout,
  input  logic               err_clr
);

  state_t        state, state_nx;
  logic [7:0]    tx_data_nx;
  logic [GW-1:0] grant_nx;
  logic [GW-1:0] rr_ptr, rr_nx, rr_adv;
  logic          lock, lock_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          err_nx;
  logic          timeout_hit;

  logic [N_REQ-1:0] pick_grant;
  logic [GW-1:0]    pick_idx;
  logic             pick_any;

  logic [7:0] req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next round-robin start is the requester after the one just served.
  assign rr_adv      = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign tx_trigger  = (state == S_TRIG);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      tx_data     <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      lock        <= 1'b0;
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      tx_data     <= tx_data_nx;
      grant_id    <= grant_nx;
      rr_ptr      <= rr_nx;
      lock        <= lock_nx;
      timer       <= timer_nx;
      err_timeout <= err_nx;
    end
  end

  // A new timeout overrides err_clr in the same cycle by assigning err_nx after the clear.
  always_comb begin
    state_nx   = state;
    tx_data_nx = tx_data;
    grant_nx   = grant_id;
    rr_nx      = rr_ptr;
    lock_nx    = lock;
    timer_nx   = timer;
    err_nx     = err_clr ? 1'b0 : err_timeout;
    req_ready  = '0;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          req_ready  = pick_grant;
          tx_data_nx = req_bytes[pick_idx];
          grant_nx   = pick_idx;
          lock_nx    = ~req_last[pick_idx];
          state_nx   = S_TRIG;
        end
      end
      S_TRIG: begin
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        timer_nx = timer + 1'b1;
        if (tx_ready) begin
          if (lock) begin
            timer_nx = '0;
            state_nx = S_HOLD;
          end else begin
            rr_nx    = rr_adv;
            state_nx = S_IDLE;
          end
        end else if (timeout_hit) begin
          err_nx   = 1'b1;
          lock_nx  = 1'b0;
          rr_nx    = rr_adv;
          state_nx = S_IDLE;
        end
      end
      S_HOLD: begin
        timer_nx = timer + 1'b1;
        if (req_valid[grant_id]) begin
          req_ready  = N_REQ'(1) << grant_id;
          tx_data_nx = req_bytes[grant_id];
          lock_nx    = ~req_last[grant_id];
          state_nx   = S_TRIG;
        end else if (timeout_hit) begin
          err_nx   = 1'b1;
          lock_nx  = 1'b0;
          rr_nx    = rr_adv;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 16-cycles-per-bit transmitter model and scripted requesters.
module tb_uart_tx_arbiter;

  localparam int N         = 4;
  localparam int T         = 400;
  localparam int FRAME_CYC = 16 * 10;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_trigger;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_timeout;
  logic           err_clr = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic stall = 1'b0;
  logic tx_active;
  int   tx_cnt;

  logic [7:0] m_data [N][8];
  logic       m_last [N][8];
  int         m_len  [N];
  int         m_pos  [N];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_trigger  (tx_trigger),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Transmitter: a frame lasts FRAME_CYC cycles after the trigger, then one tx_ready pulse.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_ready  <= 1'b0;
      tx_active <= 1'b0;
      tx_cnt    <= 0;
    end else begin
      tx_ready <= 1'b0;
      if (tx_trigger) begin
        tx_active <= 1'b1;
        tx_cnt    <= 0;
      end else if (tx_active) begin
        if (tx_cnt == FRAME_CYC - 1) begin
          tx_active <= 1'b0;
          if (!stall) tx_ready <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 1;
        end
      end
    end
  end

  // Requesters present queued bytes in order and advance on each handshake.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) m_pos[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) m_pos[i] <= m_pos[i] + 1;
    end
  end

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (m_pos[i] < m_len[i]);
      if (m_pos[i] < 8) begin
        req_data[8*i +: 8] = m_data[i][m_pos[i]];
        req_last[i]        = m_last[i][m_pos[i]];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    stall   = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < N; i++) m_len[i] = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_req(input int i, input logic [7:0] d, input logic l);
    m_data[i][m_len[i]] = d;
    m_last[i][m_len[i]] = l;
    m_len[i]++;
  endtask

  // which: 0 tx_trigger, 1 tx_ready, 2 err_timeout; cycles = negedges waited until seen.
  task automatic wait_for(input int which, input string tag, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 2000 && !seen; k++) begin
      @(negedge clk);
      cycles = k;
      case (which)
        0:       seen = tx_trigger;
        1:       seen = tx_ready;
        default: seen = err_timeout;
      endcase
    end
    if (!seen) check_output({tag, "_wait_expired"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) m_len[i] = 0;

    // Reset values
    @(negedge clk);
    resetn = 1'b0;
    #2;
    check_output("rst_busy", busy, 0);
    check_output("rst_trigger", tx_trigger, 0);
    check_output("rst_data", tx_data, 0);
    check_output("rst_grant", grant_id, 0);
    check_output("rst_err", err_timeout, 0);
    check_output("rst_ready", req_ready, 0);
    do_reset();

    // Single byte from requester 2
    load_req(2, 8'h41, 1'b1);
    #1;
    check_output("t1_ready", req_ready, 4'b0100);
    @(negedge clk);
    check_output("t1_ready_drop", req_ready, 0);
    check_output("t1_trigger", tx_trigger, 1);
    check_output("t1_data", tx_data, 8'h41);
    check_output("t1_grant", grant_id, 2);
    @(negedge clk);
    check_output("t1_trigger_pulse", tx_trigger, 0);
    wait_for(1, "t1_txr", c);
    check_output("t1_data_held", tx_data, 8'h41);
    check_output("t1_busy_at_ready", busy, 1);
    @(negedge clk);
    check_output("t1_busy_after", busy, 0);
    load_req(0, 8'h50, 1'b1);
    load_req(3, 8'h53, 1'b1);
    wait_for(0, "t1_next", c);
    check_output("t1_rr_grant", grant_id, 3);
    check_output("t1_rr_data", tx_data, 8'h53);

    // Round robin with all requesters valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      load_req(i, 8'h10 + 8'(i), 1'b1);
      load_req(i, 8'h10 + 8'(i), 1'b1);
    end
    for (int n = 0; n < 5; n++) begin
      wait_for(0, "t2_trig", c);
      check_output($sformatf("t2_grant%0d", n), grant_id, exp_order[n]);
      check_output($sformatf("t2_data%0d", n), tx_data, 8'h10 + 8'(exp_order[n]));
    end

    // Locked message from requester 1 while requester 0 waits
    do_reset();
    load_req(1, 8'hAA, 1'b0);
    load_req(1, 8'hBB, 1'b0);
    load_req(1, 8'hCC, 1'b1);
    wait_for(0, "t3_trig0", c);
    check_output("t3_grant0", grant_id, 1);
    check_output("t3_data0", tx_data, 8'hAA);
    load_req(0, 8'h01, 1'b1);
    wait_for(1, "t3_txr0", c);
    wait_for(0, "t3_trig1", c);
    check_output("t3_gap1", c, 2);
    check_output("t3_grant1", grant_id, 1);
    check_output("t3_data1", tx_data, 8'hBB);
    wait_for(1, "t3_txr1", c);
    wait_for(0, "t3_trig2", c);
    check_output("t3_gap2", c, 2);
    check_output("t3_grant2", grant_id, 1);
    check_output("t3_data2", tx_data, 8'hCC);
    wait_for(1, "t3_txr2", c);
    wait_for(0, "t3_trig3", c);
    check_output("t3_gap3", c, 2);
    check_output("t3_grant3", grant_id, 0);
    check_output("t3_data3", tx_data, 8'h01);

    // Transmitter stall, err_clr, and err_clr colliding with a new timeout
    do_reset();
    stall = 1'b1;
    load_req(0, 8'h55, 1'b1);
    load_req(1, 8'h66, 1'b1);
    wait_for(0, "t4_trig0", c);
    check_output("t4_grant0", grant_id, 0);
    wait_for(2, "t4_err", c);
    check_output("t4_err_delay", c, T + 1);
    check_output("t4_idle", busy, 0);
    @(negedge clk);
    check_output("t4_trig1", tx_trigger, 1);
    check_output("t4_grant1", grant_id, 1);
    check_output("t4_data1", tx_data, 8'h66);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_output("t4_err_cleared", err_timeout, 0);
    repeat (T - 1) @(negedge clk);
    check_output("t4_err_before_collide", err_timeout, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_output("t4_set_wins", err_timeout, 1);
    @(negedge clk);
    check_output("t4_err_sticky", err_timeout, 1);

    // Lock owner stalls after a byte with last=0
    do_reset();
    load_req(3, 8'h77, 1'b0);
    wait_for(0, "t5_trig0", c);
    check_output("t5_grant0", grant_id, 3);
    load_req(0, 8'h01, 1'b1);
    wait_for(1, "t5_txr", c);
    wait_for(2, "t5_err", c);
    check_output("t5_err_delay", c, T + 1);
    check_output("t5_idle", busy, 0);
    @(negedge clk);
    check_output("t5_trig1", tx_trigger, 1);
    check_output("t5_grant1", grant_id, 0);
    check_output("t5_data1", tx_data, 8'h01);

    // Asynchronous reset in the middle of a frame
    do_reset();
    load_req(2, 8'h9C, 1'b1);
    wait_for(0, "t6_trig", c);
    check_output("t6_grant", grant_id, 2);
    repeat (10) @(negedge clk);
    check_output("t6_busy_pre", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("t6_trigger", tx_trigger, 0);
    check_output("t6_data", tx_data, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_grant_rst", grant_id, 0);
    for (int i = 0; i < N; i++) m_len[i] = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    load_req(3, 8'h33, 1'b1);
    load_req(1, 8'h11, 1'b1);
    wait_for(0, "t6_trig_after", c);
    check_output("t6_first_grant", grant_id, 1);
    check_output("t6_first_data", tx_data, 8'h11);

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
